// File: rtl/pc_salto.sv
// PC register and branch/jump resolution with post-redirect flush and sticky alignment trap.
// Optional macro SALTOS_COMPLETOS_EN adds BLT/BGE/BLTU/BGEU decoding on top of BEQ/BNE.
module pc_salto #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CICLOS = 1
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        stall,
   input  logic        cero,
   input  logic        menor,
   input  logic        menor_u,
   input  logic        es_salto,
   input  logic        es_jal,
   input  logic        es_jalr,
   input  logic [2:0]  funct3,
   input  logic [31:0] inmediato,
   input  logic [31:0] base_jalr,
   output logic [31:0] pc,
   output logic [31:0] pc_mas4,
   output logic        tomado,
   output logic        anular,
   output logic        error_alineacion
);

   localparam logic [1:0] FlushIni = 2'(FLUSH_CICLOS);

   typedef enum logic [1:0] {StEjec, StAnula, StError} estado_e;

   estado_e     estado_q;
   logic [1:0]  cuenta_q;
   logic [31:0] pc_q;
   logic        anular_q;
   logic        error_q;

   logic        condicion;
   logic        salta;
   logic        alineado;
   logic        decide;
   logic        trampa;
   logic [31:0] destino;
   logic [31:0] destino_pc;
   logic [31:0] destino_jalr;

`ifndef SALTOS_COMPLETOS_EN
   logic unused_menor;
   assign unused_menor = menor ^ menor_u;
`endif

   always_comb begin
      condicion = 1'b0;
      unique case (funct3)
         3'b000:  condicion = cero;
         3'b001:  condicion = !cero;
`ifdef SALTOS_COMPLETOS_EN
         3'b100:  condicion = menor;
         3'b101:  condicion = !menor;
         3'b110:  condicion = menor_u;
         3'b111:  condicion = !menor_u;
`endif
         default: condicion = 1'b0;
      endcase
   end

   always_comb begin
      destino_pc   = pc_q + inmediato;
      destino_jalr = (base_jalr + inmediato) & ~32'd1;
      salta        = 1'b0;
      destino      = destino_pc;
      if (es_jal) begin
         salta = 1'b1;
      end else if (es_jalr) begin
         salta   = 1'b1;
         destino = destino_jalr;
      end else if (es_salto) begin
         salta = condicion;
      end
      alineado = (destino[1:0] == 2'b00);
      // Decisions are only live in EJEC on a non-stalled cycle.
      decide   = (estado_q == StEjec) && !stall;
      tomado   = decide && salta && alineado;
      trampa   = decide && salta && !alineado;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         estado_q <= StEjec;
         cuenta_q <= 2'd0;
         pc_q     <= RESET_PC;
         anular_q <= 1'b0;
         error_q  <= 1'b0;
      end else if (!stall) begin
         unique case (estado_q)
            StEjec: begin
               if (tomado) begin
                  pc_q     <= destino;
                  cuenta_q <= FlushIni;
                  anular_q <= 1'b1;
                  estado_q <= StAnula;
               end else if (trampa) begin
                  error_q  <= 1'b1;
                  estado_q <= StError;
               end else begin
                  pc_q <= pc_q + 32'd4;
               end
            end
            StAnula: begin
               pc_q <= pc_q + 32'd4;
               if (cuenta_q == 2'd1) begin
                  anular_q <= 1'b0;
                  estado_q <= StEjec;
               end else begin
                  cuenta_q <= cuenta_q - 2'd1;
               end
            end
            StError: begin
               estado_q <= StError;
            end
            default: estado_q <= StEjec;
         endcase
      end
   end

   assign pc               = pc_q;
   assign pc_mas4          = pc_q + 32'd4;
   assign anular           = anular_q;
   assign error_alineacion = error_q;

endmodule

// File: tb/tb_pc_salto.sv
// Randomized and directed bench for pc_salto against a cycle-level behavioural model.
module tb_pc_salto;

   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam int          FLUSH = 3;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        stall, cero, menor, menor_u, es_salto, es_jal, es_jalr;
   logic [2:0]  funct3;
   logic [31:0] inmediato, base_jalr;
   logic [31:0] pc, pc_mas4;
   logic        tomado, anular, error_alineacion;

   int checks = 0;
   int errors = 0;

   // Model state: PC, remaining flush cycles, trap flag.
   logic [31:0] m_pc;
   int          m_flush;
   logic        m_err;
   logic        ult_tomado, ult_anular;

   pc_salto #(.RESET_PC(RPC), .FLUSH_CICLOS(FLUSH)) dut (
      .clk(clk), .nreset(nreset), .stall(stall), .cero(cero), .menor(menor),
      .menor_u(menor_u), .es_salto(es_salto), .es_jal(es_jal), .es_jalr(es_jalr),
      .funct3(funct3), .inmediato(inmediato), .base_jalr(base_jalr), .pc(pc),
      .pc_mas4(pc_mas4), .tomado(tomado), .anular(anular),
      .error_alineacion(error_alineacion)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic branch_cond(input logic [2:0] f3, input logic z, input logic m,
                                        input logic mu);
      case (f3)
         3'd0: return z;
         3'd1: return !z;
`ifdef SALTOS_COMPLETOS_EN
         3'd4: return m;
         3'd5: return !m;
         3'd6: return mu;
         3'd7: return !mu;
`endif
         default: return 1'b0;
      endcase
   endfunction

   // One clock: called at negedge with inputs driven; returns at next negedge.
   task automatic ciclo();
      logic        taken;
      logic [31:0] tgt;
      logic        exp_tom;
      #1;
      taken = 1'b0;
      tgt   = m_pc + inmediato;
      if (es_jal) taken = 1'b1;
      else if (es_jalr) begin
         taken = 1'b1;
         tgt   = (base_jalr + inmediato) & 32'hFFFF_FFFE;
      end else if (es_salto) taken = branch_cond(funct3, cero, menor, menor_u);
      exp_tom = !stall && !m_err && (m_flush == 0) && taken && (tgt % 4 == 0);
      check_eq("pc", pc, m_pc);
      check_eq("pc_mas4", pc_mas4, m_pc + 32'd4);
      check_eq("tomado", 32'(tomado), 32'(exp_tom));
      check_eq("anular", 32'(anular), 32'(m_flush > 0));
      check_eq("error", 32'(error_alineacion), 32'(m_err));
      ult_tomado = tomado;
      ult_anular = anular;
      @(posedge clk);
      if (!stall && !m_err) begin
         if (m_flush > 0) begin
            m_pc = m_pc + 32'd4;
            m_flush--;
         end else if (taken && (tgt % 4 == 0)) begin
            m_pc    = tgt;
            m_flush = FLUSH;
         end else if (taken) m_err = 1'b1;
         else m_pc = m_pc + 32'd4;
      end
      @(negedge clk);
   endtask

   task automatic quiet();
      stall = 0; es_salto = 0; es_jal = 0; es_jalr = 0;
      cero = 0; menor = 0; menor_u = 0; funct3 = 0; inmediato = 0; base_jalr = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         quiet();
         ciclo();
      end
   endtask

   // Asynchronous reset mid-cycle, checked before the next rising edge.
   task automatic reset_async();
      #2 nreset = 1'b0;
      #1;
      check_eq("rst_pc", pc, RPC);
      check_eq("rst_anular", 32'(anular), 32'd0);
      check_eq("rst_error", 32'(error_alineacion), 32'd0);
      m_pc = RPC; m_flush = 0; m_err = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
   endtask

   // Lands pc on target once the flush window has drained.
   task automatic go_to(input logic [31:0] target);
      quiet();
      es_jal    = 1;
      inmediato = target - 32'(4 * FLUSH) - m_pc;
      ciclo();
      idle(FLUSH);
   endtask

   initial begin
      int n_an;
      logic [31:0] p0;
      quiet();
      @(negedge clk);
      reset_async();
      check_eq("rst_pc_mas4", pc_mas4, 32'h104);
      idle(3);
      check_eq("idle3_pc", pc, 32'h10C);

      // BEQ taken backward
      go_to(32'h200);
      quiet(); es_salto = 1; funct3 = 3'b000; cero = 1; inmediato = 32'hFFFF_FFF0;
      ciclo();
      check_eq("beq_tomado", 32'(ult_tomado), 32'd1);
      check_eq("beq_pc", pc, 32'h1F0);
      n_an = 0;
      for (int i = 0; i < FLUSH + 2; i++) begin
         quiet(); ciclo(); n_an += int'(ult_anular);
      end
      check_eq("beq_anular_len", 32'(n_an), 32'(FLUSH));

      // BEQ not taken
      go_to(32'h200);
      quiet(); es_salto = 1; funct3 = 3'b000; cero = 0; inmediato = 32'hFFFF_FFF0;
      ciclo();
      check_eq("beq_nt_pc", pc, 32'h204);
      check_eq("beq_nt_anular", 32'(anular), 32'd0);

      // JALR clears bit 0
      quiet(); es_jalr = 1; base_jalr = 32'h1001; inmediato = 0;
      ciclo();
      check_eq("jalr_pc", pc, 32'h1000);
      check_eq("jalr_err", 32'(error_alineacion), 32'd0);
      idle(FLUSH);

      // Stalled BNE then released
      p0 = pc;
      quiet(); stall = 1; es_salto = 1; funct3 = 3'b001; cero = 0; inmediato = 32'h20;
      ciclo();
      check_eq("stall_tomado", 32'(ult_tomado), 32'd0);
      check_eq("stall_pc", pc, p0);
      stall = 0;
      ciclo();
      check_eq("bne_pc", pc, p0 + 32'h20);

      // ANULA stretched by two stall cycles; es_jal inside ANULA ignored
      n_an = 0;
      for (int i = 0; i < 7; i++) begin
         quiet();
         stall  = (i == 1 || i == 2);
         es_jal = (i == 3);
         inmediato = 32'h400;
         ciclo();
         n_an += int'(ult_anular);
      end
      check_eq("anular_stall_len", 32'(n_an), 32'(FLUSH + 2));
      check_eq("anula_ignore_pc", pc, p0 + 32'h20 + 32'd20);

      // BLTU depends on the macro
      p0 = pc;
      quiet(); es_salto = 1; funct3 = 3'b110; menor_u = 1; inmediato = 32'h8;
      ciclo();
`ifdef SALTOS_COMPLETOS_EN
      check_eq("bltu_pc", pc, p0 + 32'h8);
      idle(FLUSH);
`else
      check_eq("bltu_pc", pc, p0 + 32'h4);
`endif

      // PC wrap
      go_to(32'hFFFF_FFFC);
      check_eq("wrap_mas4", pc_mas4, 32'h0);
      idle(1);
      check_eq("wrap_pc", pc, 32'h0);

      // Async reset in the middle of ANULA
      quiet(); es_jal = 1; inmediato = 32'h80;
      ciclo();
      idle(1);
      reset_async();

      // Misaligned JAL, sticky trap
      go_to(32'h40);
      quiet(); es_jal = 1; inmediato = 32'h6;
      ciclo();
      check_eq("mis_tomado", 32'(ult_tomado), 32'd0);
      check_eq("mis_pc", pc, 32'h40);
      check_eq("mis_err", 32'(error_alineacion), 32'd1);
      for (int i = 0; i < 5; i++) begin
         quiet(); es_jal = (i % 2 == 0); inmediato = 32'h8;
         ciclo();
      end
      check_eq("mis_sticky", 32'(error_alineacion), 32'd1);
      reset_async();

      // Randomized bursts
      for (int b = 0; b < 6; b++) begin
         for (int c = 0; c < 150; c++) begin
            int r;
            quiet();
            r         = int'($urandom_range(0, 7));
            stall     = ($urandom % 5 == 0);
            es_jal    = (r == 0) || ($urandom % 16 == 0);
            es_jalr   = (r == 1) || ($urandom % 16 == 0);
            es_salto  = (r >= 2 && r <= 4) || ($urandom % 8 == 0);
            funct3    = 3'($urandom);
            cero      = 1'($urandom);
            menor     = 1'($urandom);
            menor_u   = 1'($urandom);
            inmediato = 32'($urandom_range(0, 63)) * 4 - 32'd128;
            if ($urandom % 40 == 0) inmediato += 32'($urandom_range(1, 3));
            base_jalr = ($urandom & 32'hFFFF_FFFC) | 32'($urandom % 2);
            if ($urandom % 40 == 0) base_jalr |= 32'h2;
            ciclo();
         end
         reset_async();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/pc_salto.md
# pc_salto

Program-counter and branch-resolution stage for the RV32I core. It sits directly downstream of the zero detector `cero`: it consumes the `Y` flag, computed on the ALU result rs1−rs2, as `cero`. From that flag and the decoded instruction class it decides conditional branches, JAL and JALR, then registers the next PC. After every redirect it drives a multi-cycle flush pulse and traps on misaligned targets.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `FLUSH_CICLOS`, default 1: number of `anular` cycles after a redirect. Legal range 1..3.

Ports:
- `clk`  in  1: single clock, rising edge.
- `nreset`  in  1: reset, asynchronous, active-low.
- `stall`  in  1: holds PC, state and flush counter.
- `cero`  in  1: zero flag from `cero` (1 when rs1−rs2 == 0).
- `menor`  in  1: signed rs1<rs2. Used only with the macro.
- `menor_u`  in  1: unsigned rs1<rs2. Used only with the macro.
- `es_salto`  in  1: current instruction is a conditional branch.
- `es_jal`  in  1: current instruction is JAL.
- `es_jalr`  in  1: current instruction is JALR.
- `funct3`  in  3: branch condition field.
- `inmediato`  in  32: sign-extended offset.
- `base_jalr`  in  32: rs1 value for JALR.
- `pc`  out  32: current PC (registered).
- `pc_mas4`  out  32: `pc`+4, used as the link value.
- `tomado`  out  1: redirect decided this cycle (combinational).
- `anular`  out  1: kill the in-flight fetched instruction(s) (registered).
- `error_alineacion`  out  1: sticky misaligned-target trap (registered).

## Operation
- States: `EJEC`, `ANULA`, `ERROR`. Reset → `EJEC`.
- **`EJEC`, `stall`=0:**
  - Priority is `es_jal` > `es_jalr` > `es_salto`.
  - Target for JAL and branches: `pc`+`inmediato`.
  - Target for JALR: (`base_jalr`+`inmediato`) & ~1.
  - Additions are modulo 2^32; wrap-around is silent.
- **Branch condition by `funct3`:**
  - 000 BEQ: taken = `cero`.
  - 001 BNE: taken = !`cero`.
  - All other codes: never taken (macro off).
- **Taken with aligned target** (bits[1:0]==0; for JALR bit1==0):
  - `tomado`=1.
  - `pc` ← target.
  - Go to `ANULA` with counter = `FLUSH_CICLOS`.
- **Taken with misaligned target:**
  - `tomado`=0.
  - `pc` holds the faulting instruction's PC.
  - `error_alineacion` ← 1; go to `ERROR`.
- **Not taken:** `pc` ← `pc`+4. A misaligned target is ignored in this case.
- **`ANULA`:**
  - `anular`=1.
  - All decision inputs are ignored, because they belong to killed instructions.
  - `pc` ← `pc`+4 on each non-stalled cycle.
  - Counter decrements; the state moves to `EJEC` after the cycle in which the counter reaches 1.
- **`ERROR`:**
  - `pc` is frozen, `error_alineacion`=1, `tomado`=0, `anular`=0.
  - Exit only via reset.
- **`stall`=1 in any state:**
  - `pc`, state and counter hold.
  - `tomado`=0; the decision is re-evaluated when `stall` drops.
  - `anular` keeps its value.

## Timing
- Reset values: `pc`=`RESET_PC`, `pc_mas4`=`RESET_PC`+4, `tomado`=0, `anular`=0, `error_alineacion`=0, state `EJEC`.
- Decision latency: decision is made in cycle N; `pc` updates at the rising edge ending N.
- `anular` is high for the non-stalled cycles N+1 … N+`FLUSH_CICLOS`.
- Back-to-back redirects are impossible: inputs are masked in `ANULA`.
- `pc_mas4` wraps 32'hFFFF_FFFC → 32'h0000_0000.
- Reset asserted mid-`ANULA` or in `ERROR`: immediate return to reset values, independent of `clk`.

## Configuration
- `SALTOS_COMPLETOS_EN` defined:
  - `funct3` 100 BLT = `menor`.
  - 101 BGE = !`menor`.
  - 110 BLTU = `menor_u`.
  - 111 BGEU = !`menor_u`.
  - 010/011 are never taken.
- Undefined:
  - Only BEQ/BNE are decoded.
  - `menor`/`menor_u` are unused.
  - `funct3` 1xx is never taken; `pc` advances by +4.

## Test plan
- **Reset:** `nreset`=0 then released, `RESET_PC`=32'h0000_0100 → `pc`=0x100, `pc_mas4`=0x104, all flags 0; three idle cycles → `pc`=0x10C.
- **BEQ:**
  - `pc`=0x200, `es_salto`=1, `funct3`=000, `cero`=1, `inmediato`=32'hFFFF_FFF0 → `tomado`=1, next `pc`=0x1F0, `anular`=1 for exactly `FLUSH_CICLOS` cycles.
  - Same with `cero`=0 → `pc`=0x204, `anular`=0.
- **JALR:** `base_jalr`=0x1001, `inmediato`=0x0 → `pc`=0x1000, no error.
- **Misaligned JAL:** `pc`=0x40, `es_jal`=1, `inmediato`=0x6 → `pc` stays 0x40, `error_alineacion`=1 and sticky while `es_jal` toggles for 5 cycles; cleared only by reset.
- **Stall and `ANULA`:**
  - `stall`=1 during a taken BNE → `pc` and state unchanged, `tomado`=0.
  - With `FLUSH_CICLOS`=3, a redirect then `stall` for 2 cycles in `ANULA` → `anular` high for 5 cycles total.
  - Inputs with `es_jal`=1 during `ANULA` → ignored.
- **Macro and wrap:**
  - With `SALTOS_COMPLETOS_EN`: BLTU, `menor_u`=1, `inmediato`=0x8 → taken. Without it: same stimulus → `pc`+4.
  - `pc`=32'hFFFF_FFFC, not taken → `pc`=0.
